// File: rtl/pc_fetch.sv
// Instruction fetch: pc register, single-outstanding memory request FSM,
// and a registered IF output bundle held until decode accepts it.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    OUT,
    DROP
  } state_t;

  localparam logic [31:0] ALIGN = 32'hFFFF_FFFC;
  localparam logic [31:0] PC0   = RESET_PC & ALIGN;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt;
  logic        cap;

  assign tgt       = redirect_pc & ALIGN;
  assign imem_req  = (state_q == REQ);
  assign imem_addr = pc_q;
  assign if_valid  = (state_q == OUT);

  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        // a granted request that is redirected still owes us a beat
        if (imem_gnt)
          state_d = redirect ? DROP : WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d = redirect ? REQ : OUT;
          cap     = !redirect;
        end else if (redirect) begin
          state_d = DROP;
        end
      end
      OUT: begin
        if (redirect || if_ready)
          state_d = REQ;
      end
      DROP: begin
        if (imem_rvalid)
          state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    unique case (1'b1)
      redirect: pc_d = tgt;
      cap:      pc_d = pc_q + 32'd4;
      default:  pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= PC0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_pc    <= 32'h0;
      if_instr <= 32'h0;
    end else if (cap) begin
      if_pc    <= pc_q;
      if_instr <= imem_rdata;
    end
  end

endmodule
